// File: rtl/uart_tx_frame_checker.sv
// Protocol checker for the UART transmitter: rebuilds each frame from busy/TX_OUT and reports violations.
// Optional idle-line check is compiled in when UART_CHK_IDLE_LINE_EN is defined.
module uart_tx_frame_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int BUSY_LAT_MAX = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  busy,
    input  logic                  TX_OUT,
    input  logic                  clr_err,
    output logic [6:0]            err_flags,
    output logic                  err_pulse,
    output logic                  frame_ok,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      err_cnt
);
    localparam int LAT_W = (BUSY_LAT_MAX > 1) ? $clog2(BUSY_LAT_MAX) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(BUSY_LAT_MAX - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]       STOP_END = 2'(STOP_BITS);

    localparam int E_LAT   = 0;
    localparam int E_START = 1;
    localparam int E_DATA  = 2;
    localparam int E_PAR   = 3;
    localparam int E_STOP  = 4;
    localparam int E_DROP  = 5;
    localparam int E_LONG  = 6;

    typedef enum logic [2:0] {IDLE, WAIT_BUSY, DATA, PARITY, STOP, DRAIN} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] data_sh, data_sh_d;
    logic                  par_en_q, par_en_d;
    logic                  par_exp, par_exp_d;
    logic [LAT_W-1:0]      lat_cnt, lat_cnt_d;
    logic [BIT_W-1:0]      bit_idx, bit_idx_d;
    logic [1:0]            stop_idx, stop_idx_d;
    logic                  frame_err, frame_err_d;
    logic [6:0]            frame_new, err_new;
    logic                  frame_end, ok_d, idle_line_err;

`ifdef UART_CHK_IDLE_LINE_EN
    assign idle_line_err = ((state == IDLE) || (state == WAIT_BUSY)) && !busy && !TX_OUT;
`else
    assign idle_line_err = 1'b0;
`endif

    assign err_new = frame_new | (7'(idle_line_err) << E_STOP);

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d     = state;
        data_sh_d   = data_sh;
        par_en_d    = par_en_q;
        par_exp_d   = par_exp;
        lat_cnt_d   = lat_cnt;
        bit_idx_d   = bit_idx;
        stop_idx_d  = stop_idx;
        frame_err_d = frame_err;
        frame_new   = '0;
        frame_end   = 1'b0;
        ok_d        = 1'b0;

        unique case (state)
            IDLE: begin
                if (data_valid && !busy) begin
                    data_sh_d   = P_DATA;
                    par_en_d    = par_en;
                    par_exp_d   = par_typ ? ~^P_DATA : ^P_DATA;
                    frame_err_d = 1'b0;
                    lat_cnt_d   = '0;
                    state_d     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // The clock on which busy rises carries the start bit.
                if (busy) begin
                    frame_new[E_START] = TX_OUT;
                    bit_idx_d          = '0;
                    state_d            = DATA;
                end else if (lat_cnt == LAT_LAST) begin
                    frame_new[E_LAT] = 1'b1;
                    frame_end        = 1'b1;
                    state_d          = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt + LAT_W'(1);
                end
            end
            DATA: begin
                if (!busy) begin
                    frame_new[E_DROP] = 1'b1;
                    frame_end         = 1'b1;
                    state_d           = IDLE;
                end else begin
                    frame_new[E_DATA] = (TX_OUT != data_sh[0]);
                    data_sh_d         = data_sh >> 1;
                    bit_idx_d         = bit_idx + BIT_W'(1);
                    if (bit_idx == BIT_LAST) begin
                        stop_idx_d = '0;
                        state_d    = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    frame_new[E_DROP] = 1'b1;
                    frame_end         = 1'b1;
                    state_d           = IDLE;
                end else begin
                    frame_new[E_PAR] = (TX_OUT != par_exp);
                    stop_idx_d       = '0;
                    state_d          = STOP;
                end
            end
            STOP: begin
                // stop_idx == STOP_END is the first clock after the last stop bit.
                if (stop_idx == STOP_END) begin
                    frame_end = 1'b1;
                    if (busy) begin
                        frame_new[E_LONG] = 1'b1;
                        state_d           = DRAIN;
                    end else begin
                        ok_d    = !frame_err;
                        state_d = IDLE;
                    end
                end else if (!busy) begin
                    frame_new[E_DROP] = 1'b1;
                    frame_end         = 1'b1;
                    state_d           = IDLE;
                end else begin
                    frame_new[E_STOP] = !TX_OUT;
                    stop_idx_d        = stop_idx + 2'd1;
                end
            end
            DRAIN: begin
                if (!busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        frame_err_d = frame_err_d | (|frame_new);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            data_sh   <= '0;
            par_en_q  <= 1'b0;
            par_exp   <= 1'b0;
            lat_cnt   <= '0;
            bit_idx   <= '0;
            stop_idx  <= '0;
            frame_err <= 1'b0;
            err_flags <= '0;
            err_pulse <= 1'b0;
            frame_ok  <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            data_sh   <= data_sh_d;
            par_en_q  <= par_en_d;
            par_exp   <= par_exp_d;
            lat_cnt   <= lat_cnt_d;
            bit_idx   <= bit_idx_d;
            stop_idx  <= stop_idx_d;
            frame_err <= frame_err_d;
            err_flags <= (clr_err ? 7'b0 : err_flags) | err_new;
            err_pulse <= |err_new;
            frame_ok  <= ok_d;
            if (frame_end) frame_cnt <= frame_cnt + CNT_W'(1);
            // A frame ending in error on the clearing clock still counts once.
            if (clr_err)
                err_cnt <= (frame_end && frame_err_d) ? CNT_W'(1) : '0;
            else if (frame_end && frame_err_d && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule
